weighted_ring_arbiter: RTL
==========================

# weighted_ring_arbiter

Packet-aware, weighted round-robin arbiter with an integrated data mux and registered output stage. It merges PORTS valid/ready input streams onto one output stream. A grant is held for whole packets, and each port may send up to a programmable number of packets per turn before the ring advances. It is the next generation of the ring arbiter in the arbiters library and sits in front of shared single-ported consumers such as FIFOs and serializers.

## Interface
- PORTS, 4: number of input ports; must be ≥ 2.
- WIDTH, 8: data width per port.
- WEIGHT_W, 4: width of each per-port weight field.
- PW (localparam): $clog2(PORTS), the port-index width.

Ports:
- i_clock  in  1  clock; all logic is on its rising edge.
- i_aresetn  in  1  reset; **synchronous, active-low** (sampled only on the rising edge of i_clock).
- i_data  in  PORTS*WIDTH  port p data is bits [p*WIDTH +: WIDTH].
- i_valid  in  PORTS  per-port beat valid.
- i_last  in  PORTS  per-port end-of-packet marker, qualified by i_valid.
- i_weights  in  PORTS*WEIGHT_W  packets per turn for port p, in bits [p*WEIGHT_W +: WEIGHT_W]; a value of 0 is treated as 1.
- o_ready  out  PORTS  per-port accept; at most one bit is high.
- o_data  out  WIDTH  registered output beat.
- o_last  out  1  registered end-of-packet marker.
- o_port  out  PW  index of the port that sourced o_data.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accept.

## Operation
- **Transfer rules**
  - A beat transfers on an input when i_valid[p] & o_ready[p].
  - A beat transfers on the output when o_valid & i_ready.
- **State machine** (states IDLE and BUSY). Registers: owner, credit (WEIGHT_W bits), ptr (last owner), mid_pkt.
- **IDLE**
  - o_ready = 0.
  - If any i_valid is high: select the first set bit of i_valid, searching ring order ptr+1, ptr+2, … (mod PORTS).
  - Then set owner = that port, credit = max(i_weights[owner], 1), mid_pkt = 0, and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - o_ready[owner] = (!o_valid | i_ready); all other o_ready bits are 0.
  - A transfer with i_last=0 sets mid_pkt = 1.
  - A transfer with i_last=1 clears mid_pkt and decrements credit. If credit becomes 0: set ptr = owner and go to IDLE.
  - If mid_pkt = 0 and i_valid[owner] = 0 in a cycle: release. Set ptr = owner, go to IDLE, and transfer no beat.
  - If mid_pkt = 1 and i_valid[owner] drops: hold the grant (packet lock) and wait indefinitely.
- **Weights** are sampled only at grant time. Changing i_weights during BUSY has no effect until the next grant.
- **Output register**
  - On an input transfer, load o_data/o_last/o_port from the owner and set o_valid = 1.
  - On an output transfer with no input transfer, clear o_valid.
  - If both transfers occur in the same cycle, the new beat replaces the old one, giving full throughput.
- Beats and i_last are never dropped, duplicated or reordered within a port.
- **Reset** (i_aresetn = 0 at an edge): state = IDLE, ptr = PORTS-1 (so port 0 has first priority), owner = 0, credit = 0, mid_pkt = 0, o_valid = 0, o_data = 0, o_last = 0, o_port = 0.
  - o_ready is 0 from that edge onward.
  - Reset mid-packet abandons the packet; no further output beat is produced for it.

## Timing
- Arbitration latency: i_valid rising while in IDLE at edge N means the grant is registered at N, o_ready rises after N, and the first beat transfers at edge N+1.
- Data latency: an input transfer at edge M puts the beat on o_data/o_valid after edge M.
- Throughput: 1 beat/cycle while i_ready = 1 and the owner keeps i_valid high.
- Owner switch costs exactly one IDLE cycle with o_ready = 0.
- Backpressure: with o_valid = 1 and i_ready = 0, o_ready is 0 in that same cycle (combinational from i_ready).
- Outputs o_data/o_last/o_port/o_valid hold stable while o_valid & !i_ready.

## Test plan
- **Reset:** hold i_aresetn = 0 for 3 cycles with all i_valid = 1 → o_valid = 0, o_ready = 0, o_data = 0. First grant after release goes to port 0 (o_port = 0).
- **Fair ring:** PORTS = 4, weights all 1, all ports stream single-beat packets (i_last = 1), i_ready = 1 → o_port sequence 0,1,2,3,0,…, with one bubble between grants.
- **Weights:** weights {3,1,0,2}, all ports continuously send 2-beat packets → per turn, port 0 sends 3 packets (6 beats), port 1 sends 1, port 2 sends 1 (weight 0→1), port 3 sends 2, then the ring repeats.
- **Packet lock:** port 1 sends beat 0 (i_last = 0), then deasserts i_valid for 5 cycles while port 2 is valid → o_ready[2] stays 0. Port 1's last beat arrives next on o_data with o_last = 1, then port 2 is granted.
- **Early release:** port 0 has weight 4 and sends 1 packet, then drops i_valid → release next cycle and port 1 is granted without waiting for the unused credit.
- **Backpressure:** toggle i_ready randomly with 5 ports and WIDTH = 16 against a scoreboard → no loss, duplication or reordering per port; o_data stable while !i_ready; at most one o_ready bit high in every cycle.

Source files
------------

// File: rtl/weighted_ring_arbiter.sv
// Packet-aware weighted round-robin arbiter: merges PORTS valid/ready streams
// onto one registered output, holding each grant for whole packets.
module weighted_ring_arbiter #(
  parameter int  PORTS    = 4,
  parameter int  WIDTH    = 8,
  parameter int  WEIGHT_W = 4,
  localparam int PW       = $clog2(PORTS)
) (
  input  logic                      i_clock,
  input  logic                      i_aresetn,
  input  logic [PORTS*WIDTH-1:0]    i_data,
  input  logic [PORTS-1:0]          i_valid,
  input  logic [PORTS-1:0]          i_last,
  input  logic [PORTS*WEIGHT_W-1:0] i_weights,
  output logic [PORTS-1:0]          o_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_last,
  output logic [PW-1:0]             o_port,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_dbg_state
);

  // Handshake: a beat moves on an input when i_valid[p] & o_ready[p], and on
  // the output when o_valid & i_ready; o_ready never depends on i_valid.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q;
  logic [PW-1:0]       owner_q;
  logic [PW-1:0]       ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic                mid_pkt_q;
  logic                o_valid_q;
  logic                o_last_q;
  logic [WIDTH-1:0]    o_data_q;
  logic [PW-1:0]       o_port_q;

  logic [WIDTH-1:0]    data_arr   [PORTS];
  logic [WEIGHT_W-1:0] weight_arr [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_unpack
    assign data_arr[p]   = i_data[p*WIDTH +: WIDTH];
    assign weight_arr[p] = i_weights[p*WEIGHT_W +: WEIGHT_W];
  end

  logic          found;
  logic [PW-1:0] pick;

  // First requester after the last owner, wrapping modulo PORTS.
  always_comb begin : ring_search
    logic [PW:0] cand;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(PORTS)) cand = cand - (PW+1)'(PORTS);
      if (!found && i_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = cand[PW-1:0];
      end
    end
  end

  logic [WEIGHT_W-1:0] pick_weight;
  logic [WEIGHT_W-1:0] grant_credit;
  logic [WEIGHT_W-1:0] credit_d;
  logic                own_valid;
  logic                own_last;
  logic                in_xfer;
  logic                out_xfer;

  assign pick_weight  = weight_arr[pick];
  assign grant_credit = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;
  assign credit_d     = credit_q - WEIGHT_W'(1);
  assign own_valid    = i_valid[owner_q];
  assign own_last     = i_last[owner_q];
  assign in_xfer      = (state_q == BUSY) && own_valid && (!o_valid_q || i_ready);
  assign out_xfer     = o_valid_q && i_ready;

  always_comb begin
    o_ready = '0;
    if (state_q == BUSY) o_ready[owner_q] = !o_valid_q || i_ready;
  end

  always_ff @(posedge i_clock) begin
    if (!i_aresetn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= PW'(PORTS-1);
      credit_q  <= '0;
      mid_pkt_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_port_q  <= '0;
    end else begin
      // A fresh beat overwrites one leaving in the same cycle.
      if (in_xfer) begin
        o_valid_q <= 1'b1;
        o_data_q  <= data_arr[owner_q];
        o_last_q  <= own_last;
        o_port_q  <= owner_q;
      end else if (out_xfer) begin
        o_valid_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (found) begin
            owner_q   <= pick;
            credit_q  <= grant_credit;
            mid_pkt_q <= 1'b0;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer) begin
            if (own_last) begin
              mid_pkt_q <= 1'b0;
              credit_q  <= credit_d;
              if (credit_d == '0) begin
                ptr_q   <= owner_q;
                state_q <= IDLE;
              end
            end else begin
              mid_pkt_q <= 1'b1;
            end
          end else if (!mid_pkt_q && !own_valid) begin
            // Owner idle between packets: give up the rest of its turn.
            ptr_q   <= owner_q;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_valid     = o_valid_q;
  assign o_data      = o_data_q;
  assign o_last      = o_last_q;
  assign o_port      = o_port_q;
  assign o_dbg_state = (state_q == BUSY);

endmodule
